ofdm_pingpong_buffer: RTL and testbench



---
 rtl/ofdm_buf_pkg.sv | 19 +
 rtl/ofdm_sdp_ram.sv | 37 +++
 rtl/ofdm_pingpong_buffer.sv | 120 ++++++++++++
 tb/tb_ofdm_pingpong_buffer.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ofdm_buf_pkg.sv
// rtl/ofdm_buf_pkg.sv - shared constants, bank type and bit-reverse helper for the ping-pong buffer
package ofdm_buf_pkg;

    localparam int DEF_DATA_W = 13;
    localparam int DEF_DEPTH  = 64;
    localparam int DEF_NUM_CH = 2;
    localparam int MAX_ADDR_W = 16;

    typedef logic bank_t;

    // Reverse the low addr_w bits of idx; callers truncate the result to addr_w bits.
    function automatic logic [MAX_ADDR_W-1:0] bitrev(input logic [MAX_ADDR_W-1:0] idx,
                                                     input int unsigned addr_w);
        logic [MAX_ADDR_W-1:0] r;
        r = {<<{idx}};
        return r >> (MAX_ADDR_W - addr_w);
    endfunction

endpackage

// File: rtl/ofdm_sdp_ram.sv
// rtl/ofdm_sdp_ram.sv - simple dual-port RAM with registered read port, zeroed output unless read or held
module ofdm_sdp_ram #(
    parameter int WIDTH = 26,
    parameter int DEPTH = 128,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic             hold,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // hold keeps a stalled sample on the output instead of zeroing it
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[raddr];
        end else if (!hold) begin
            rdata <= '0;
        end
    end

endmodule

// File: rtl/ofdm_pingpong_buffer.sv
// rtl/ofdm_pingpong_buffer.sv - multi-channel ping-pong OFDM symbol buffer; BITREV_EN enables bit-reversed reads
module ofdm_pingpong_buffer
    import ofdm_buf_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic                     rd_valid,
    input  logic                     rd_ready,
    output logic [NUM_CH*DATA_W-1:0] rd_data,
    output logic                     rd_last,
    input  logic                     rd_bitrev,
    output logic [1:0]               bank_full
);

    localparam int W = NUM_CH * DATA_W;
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    bank_t             wr_bank, rd_bank;
    logic [ADDR_W-1:0] wr_cnt, rd_cnt, rd_addr;
    logic [1:0]        full_q, full_nxt;
    logic              valid_q, last_q;
    logic              wr_fire, wr_done, advance, rd_done;

    assign wr_ready  = !full_q[wr_bank];
    assign wr_fire   = wr_valid && wr_ready;
    assign wr_done   = wr_fire && (wr_cnt == LAST);
    assign advance   = full_q[rd_bank] && (!valid_q || rd_ready);
    assign rd_done   = advance && (rd_cnt == LAST);
    assign bank_full = full_q;
    assign rd_valid  = valid_q;
    assign rd_last   = last_q;

`ifdef BITREV_EN
    logic rev_q, use_rev;

    // The order for a symbol is chosen at its first read and frozen until its last.
    assign use_rev = (rd_cnt == '0) ? rd_bitrev : rev_q;
    assign rd_addr = use_rev ? ADDR_W'(bitrev(MAX_ADDR_W'(rd_cnt), ADDR_W)) : rd_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            rev_q <= 1'b0;
        end else if (advance && (rd_cnt == '0)) begin
            rev_q <= rd_bitrev;
        end
    end
`else
    logic unused_bitrev;

    assign unused_bitrev = rd_bitrev;
    assign rd_addr       = rd_cnt;
`endif

    // Set and clear always target different banks, so both may land in one edge.
    always_comb begin
        full_nxt = full_q;
        if (rd_done) begin
            full_nxt[rd_bank] = 1'b0;
        end
        if (wr_done) begin
            full_nxt[wr_bank] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_bank <= 1'b0;
            rd_bank <= 1'b0;
            wr_cnt  <= '0;
            rd_cnt  <= '0;
            full_q  <= 2'b00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            full_q <= full_nxt;
            if (wr_fire) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_done) begin
                    wr_bank <= ~wr_bank;
                end
            end
            if (advance) begin
                rd_cnt  <= rd_cnt + 1'b1;
                valid_q <= 1'b1;
                last_q  <= (rd_cnt == LAST);
                if (rd_done) begin
                    rd_bank <= ~rd_bank;
                end
            end else if (rd_ready) begin
                valid_q <= 1'b0;
                last_q  <= 1'b0;
            end
        end
    end

    ofdm_sdp_ram #(
        .WIDTH (W),
        .DEPTH (2 * DEPTH),
        .AW    (ADDR_W + 1)
    ) u_ram (
        .clk   (clk),
        .rst   (rst),
        .we    (wr_fire),
        .waddr ({wr_bank, wr_cnt}),
        .wdata (wr_data),
        .re    (advance),
        .hold  (valid_q && !rd_ready),
        .raddr ({rd_bank, rd_addr}),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_ofdm_pingpong_buffer.sv
// tb/tb_ofdm_pingpong_buffer.sv - randomized self-checking bench for ofdm_pingpong_buffer
module tb_ofdm_pingpong_buffer;

    localparam int DATA_W = 13;
    localparam int DEPTH  = 64;
    localparam int NUM_CH = 2;
    localparam int W      = NUM_CH * DATA_W;

    logic         clk = 1'b0;
    logic         rst, wr_valid, wr_ready, rd_valid, rd_ready, rd_last, rd_bitrev;
    logic [W-1:0] wr_data, rd_data;
    logic [1:0]   bank_full;

    always #5 clk = ~clk;

    ofdm_pingpong_buffer #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .NUM_CH (NUM_CH)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_data   (wr_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_last   (rd_last),
        .rd_bitrev (rd_bitrev),
        .bank_full (bank_full)
    );

    int           errors = 0;
    int           checks = 0;
    int           rd_mode = 0;
    bit           cur_rev = 0;
    bit           wr_acc = 0;
    bit           prev_stall = 0;
    logic [W-1:0] prev_data;
    logic         prev_last;
    logic [1:0]   bf_at_neg;
    logic [W-1:0] exp_q[$];
    bit           exp_last_q[$];
    logic [W-1:0] sym_buf[$];

    // Reference order: reverse the 6 index bits arithmetically.
    function automatic int rev_idx(input int x);
        int r = 0;
        for (int k = 0; k < 6; k++) begin
            r = r * 2 + (x % 2);
            x = x / 2;
        end
        return r;
    endfunction

    task automatic monitor();
        logic [W-1:0] e;
        bit           el;
        wr_acc    = 0;
        bf_at_neg = bank_full;
        if (rst) begin
            exp_q.delete();
            exp_last_q.delete();
            sym_buf.delete();
            prev_stall = 0;
            return;
        end
        if (wr_valid && wr_ready) begin
            wr_acc = 1;
            sym_buf.push_back(wr_data);
            if (sym_buf.size() == DEPTH) begin
                for (int j = 0; j < DEPTH; j++) begin
                    exp_q.push_back(sym_buf[cur_rev ? rev_idx(j) : j]);
                    exp_last_q.push_back(j == DEPTH - 1);
                end
                sym_buf.delete();
            end
        end
        if (prev_stall) begin
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== prev_data || rd_last !== prev_last) begin
                errors++;
                $display("FAIL stall_hold: valid=%0b data=%h last=%0b required valid=1 data=%h last=%0b",
                         rd_valid, rd_data, rd_last, prev_data, prev_last);
            end
        end
        if (!rd_valid) begin
            checks++;
            if (rd_data !== '0 || rd_last !== 1'b0) begin
                errors++;
                $display("FAIL idle_zero: data=%h last=%0b required data=0 last=0", rd_data, rd_last);
            end
        end
        if (rd_valid && rd_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_output: data=%h required no output", rd_data);
            end else begin
                e  = exp_q.pop_front();
                el = exp_last_q.pop_front();
                if (rd_data !== e || rd_last !== el) begin
                    errors++;
                    $display("FAIL read_data: data=%h last=%0b required data=%h last=%0b",
                             rd_data, rd_last, e, el);
                end
            end
        end
        prev_stall = rd_valid && !rd_ready;
        prev_data  = rd_data;
        prev_last  = rd_last;
    endtask

    task automatic set_mode(input int m);
        rd_mode  = m;
        rd_ready = (m == 2) ? 1'($urandom % 2) : (m == 1);
    endtask

    task automatic step();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        rd_ready = (rd_mode == 2) ? 1'($urandom % 2) : (rd_mode == 1);
    endtask

    task automatic write_stream(input int n, input int start, input bit rnd);
        int  budget;
        bit  timed_out = 0;
        for (int i = 0; i < n && !timed_out; i++) begin
            wr_valid = 1'b1;
            wr_data  = rnd ? W'($urandom) : {13'(start + i + 100), 13'(start + i)};
            budget   = 0;
            do begin
                step();
                budget++;
            end while (!wr_acc && budget < 400);
            if (!wr_acc) timed_out = 1;
        end
        wr_valid = 1'b0;
        checks++;
        if (timed_out) begin
            errors++;
            $display("FAIL write_timeout: wr_ready=%0b bank_full=%b required accepted within 400 cycles",
                     wr_ready, bank_full);
        end
    endtask

    task automatic drain(input int budget, input bit toggle);
        int c = 0;
        while ((exp_q.size() != 0 || rd_valid) && c < budget) begin
            if (toggle) rd_bitrev = 1'($urandom % 2);
            step();
            c++;
        end
        checks++;
        if (exp_q.size() != 0 || rd_valid) begin
            errors++;
            $display("FAIL drain_timeout: pending=%0d rd_valid=%0b required 0 and 0", exp_q.size(), rd_valid);
        end
    endtask

    task automatic apply_reset();
        rst      = 1'b1;
        wr_valid = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        checks += 5;
        if (wr_ready !== 1'b1) begin errors++; $display("FAIL %s_wr_ready: got %0b required 1", tag, wr_ready); end
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL %s_rd_valid: got %0b required 0", tag, rd_valid); end
        if (rd_data !== '0) begin errors++; $display("FAIL %s_rd_data: got %h required 0", tag, rd_data); end
        if (rd_last !== 1'b0) begin errors++; $display("FAIL %s_rd_last: got %0b required 0", tag, rd_last); end
        if (bank_full !== 2'b00) begin errors++; $display("FAIL %s_bank_full: got %b required 00", tag, bank_full); end
    endtask

    task automatic test_reset();
        set_mode(0);
        apply_reset();
        check_reset_outputs("reset");
    endtask

    task automatic test_single();
        set_mode(1);
        cur_rev = 0;
        write_stream(64, 0, 0);
        checks += 2;
        if (rd_valid !== 1'b0) begin errors++; $display("FAIL latency_early: rd_valid=%0b required 0", rd_valid); end
        if (bank_full !== 2'b01) begin errors++; $display("FAIL single_full: got %b required 01", bank_full); end
        step();
        checks++;
        if (rd_valid !== 1'b1) begin errors++; $display("FAIL latency_rise: rd_valid=%0b required 1", rd_valid); end
        drain(200, 0);
        checks++;
        if (bank_full !== 2'b00) begin errors++; $display("FAIL single_empty: got %b required 00", bank_full); end
    endtask

    task automatic test_back_to_back();
        set_mode(0);
        write_stream(128, 0, 1);
        checks += 2;
        if (wr_ready !== 1'b0) begin errors++; $display("FAIL b2b_wr_ready: got %0b required 0", wr_ready); end
        if (bank_full !== 2'b11) begin errors++; $display("FAIL b2b_full: got %b required 11", bank_full); end
        set_mode(1);
        write_stream(64, 0, 1);
        drain(300, 0);
    endtask

    task automatic test_random_stall();
        set_mode(2);
        write_stream(128, 0, 1);
        drain(2000, 0);
    endtask

    task automatic test_bitrev();
        set_mode(1);
`ifdef BITREV_EN
        rd_bitrev = 1'b1;
        cur_rev   = 1;
        write_stream(64, 0, 0);
        step();
        drain(300, 1);
`else
        rd_bitrev = 1'b1;
        cur_rev   = 0;
        write_stream(64, 0, 0);
        drain(300, 1);
`endif
        rd_bitrev = 1'b0;
        cur_rev   = 0;
        write_stream(64, 0, 1);
        drain(300, 0);
    endtask

    task automatic test_simultaneous();
        int gaps = 0;
        apply_reset();
        set_mode(0);
        write_stream(64, 0, 1);
        write_stream(1, 0, 0);
        set_mode(1);
        write_stream(63, 1, 0);
        checks += 2;
        if (bf_at_neg !== 2'b01) begin errors++; $display("FAIL simul_before: got %b required 01", bf_at_neg); end
        if (bank_full !== 2'b10) begin errors++; $display("FAIL simul_after: got %b required 10", bank_full); end
        for (int i = 0; i < 64; i++) begin
            step();
            if (!rd_valid) gaps++;
        end
        checks++;
        if (gaps != 0) begin errors++; $display("FAIL simul_gap: got %0d idle cycles required 0", gaps); end
        drain(200, 0);
    endtask

    task automatic test_reset_mid();
        set_mode(1);
        write_stream(64, 0, 1);
        write_stream(40, 0, 1);
        rst = 1'b1;
        step();
        check_reset_outputs("midreset");
        rst = 1'b0;
        set_mode(0);
        write_stream(64, 0, 0);
        checks++;
        if (bank_full !== 2'b01) begin errors++; $display("FAIL fresh_bank0: got %b required 01", bank_full); end
        set_mode(1);
        drain(200, 0);
    endtask

    initial begin
        rst       = 1'b1;
        wr_valid  = 1'b0;
        wr_data   = '0;
        rd_ready  = 1'b0;
        rd_bitrev = 1'b0;
        test_reset();
        test_single();
        test_back_to_back();
        test_random_stall();
        test_bitrev();
        test_simultaneous();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
